// File: rtl/bus_arbiter_if.sv
// Bus-arbitration signal bundle: requests and freeze in, one-hot grant plus status out.
// The arbiter takes the slave view; whatever drives requests takes the master view.
interface bus_arbiter_if;
  logic [2:0] req;
  logic       freeze;
  logic [2:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       preempt;

  modport slave  (input  req, freeze, output gnt, owner, busy, preempt);
  modport master (output req, freeze, input  gnt, owner, busy, preempt);
endinterface

// File: rtl/bus_arbiter.sv
// Three-requester round-robin arbiter for data_bus with hold-time preemption
// and an optional all-grants-low turnaround gap between owners.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic           clk,
  input  logic           reset,
  bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam logic [7:0] MAX_HOLD_C   = 8'(MAX_HOLD);
  localparam logic [1:0] TURNAROUND_C = 2'(TURNAROUND);

  state_t     state_q, state_d;
  logic [2:0] gnt_q, gnt_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] turn_q, turn_d;
  logic       preempt_q, preempt_d;

  logic [1:0] owner_idx;
  logic [1:0] cand1, cand2;
  logic [1:0] win_idx;
  logic       others_pending;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    owner_idx = 2'd3;
    if (gnt_q[0])      owner_idx = 2'd0;
    else if (gnt_q[1]) owner_idx = 2'd1;
    else if (gnt_q[2]) owner_idx = 2'd2;
  end

  // Search starts just after the last winner, so the last winner is tried last.
  always_comb begin
    cand1   = inc3(last_q);
    cand2   = inc3(cand1);
    win_idx = last_q;
    if (bus.req[cand1])      win_idx = cand1;
    else if (bus.req[cand2]) win_idx = cand2;
  end

  assign others_pending = |(bus.req & ~gnt_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    preempt_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.freeze && (bus.req != 3'b000)) begin
          gnt_d   = 3'b001 << win_idx;
          last_d  = win_idx;
          hold_d  = 8'd1;
          state_d = GRANT;
        end
      end

      GRANT: begin
        // Release wins over expiry when both happen on the same edge.
        if (!bus.req[owner_idx] || ((hold_q == MAX_HOLD_C) && others_pending)) begin
          gnt_d     = 3'b000;
          hold_d    = 8'd0;
          preempt_d = bus.req[owner_idx];
          if (TURNAROUND == 0) begin
            state_d = IDLE;
          end else begin
            state_d = TURN;
            turn_d  = 2'd1;
          end
        end else if (hold_q != MAX_HOLD_C) begin
          hold_d = hold_q + 8'd1;
        end
      end

      TURN: begin
        if (turn_q >= TURNAROUND_C) state_d = IDLE;
        else                        turn_d  = turn_q + 2'd1;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= 3'b000;
      last_q    <= 2'd2;
      hold_q    <= 8'd0;
      turn_q    <= 2'd0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_idx;
  assign bus.busy    = (state_q != IDLE);
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based round-robin reference model.
module tb_bus_arbiter;
  localparam int MAX_HOLD   = 16;
  localparam int TURNAROUND = 1;

  logic clk = 1'b0;
  logic reset;

  bus_arbiter_if bus ();

  bus_arbiter #(.MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // Reference model: current owner (-1 none), cycles held, remaining quiet cycles,
  // preempt flag, and the priority order as a rotating queue.
  int   cur;
  int   held;
  int   quiet;
  logic pre;
  int   prio[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur   = -1;
    held  = 0;
    quiet = 0;
    pre   = 1'b0;
    prio  = {0, 1, 2};
  endtask

  task automatic model_step(input logic [2:0] r, input logic f);
    pre = 1'b0;
    if (cur >= 0) begin
      if (!r[cur]) begin
        cur   = -1;
        quiet = TURNAROUND;
      end else if (held == MAX_HOLD && (r & ~(3'b001 << cur)) != 3'b000) begin
        cur   = -1;
        quiet = TURNAROUND;
        pre   = 1'b1;
      end else if (held < MAX_HOLD) begin
        held++;
      end
    end else if (quiet > 0) begin
      quiet--;
    end else if (!f && r != 3'b000) begin
      foreach (prio[i]) if (cur < 0 && r[prio[i]]) cur = prio[i];
      held = 1;
      while (prio[$] != cur) begin
        int t;
        t = prio.pop_front();
        prio.push_back(t);
      end
    end
  endtask

  task automatic compare();
    check("gnt",     bus.gnt,     (cur < 0) ? 8'h00 : 8'(1 << cur));
    check("owner",   bus.owner,   (cur < 0) ? 8'd3  : 8'(cur));
    check("busy",    bus.busy,    8'(cur >= 0 || quiet > 0));
    check("preempt", bus.preempt, 8'(pre));
    if (cur >= 0) check("hold_cnt", dut.hold_q, 8'(held));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(bus.req, bus.freeze);
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset      = 1'b0;
    bus.req    = 3'b000;
    bus.freeze = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("rst_gnt",     bus.gnt,     8'h00);
    check("rst_owner",   bus.owner,   8'd3);
    check("rst_busy",    bus.busy,    8'd0);
    check("rst_preempt", bus.preempt, 8'd0);
    check("rst_hold",    dut.hold_q,  8'd0);

    // No grant while reset is still low, even with requests pending
    @(negedge clk) bus.req = 3'b111;
    @(posedge clk);
    @(negedge clk);
    check("no_gnt_in_reset", bus.gnt, 8'h00);
    reset = 1'b1;

    // All three requesting: rotation with preemption
    cycle();
    check("first_winner", bus.gnt, 8'h01);
    run(70);

    // Single short request, then release
    bus.req = 3'b000;
    run(4);
    bus.req = 3'b010;
    run(5);
    bus.req = 3'b000;
    run(4);

    // Lone requester held past MAX_HOLD: saturation, no preempt
    bus.req = 3'b001;
    run(40);
    check("hold_sat", dut.hold_q, 8'(MAX_HOLD));
    bus.req = 3'b000;
    run(4);

    // Release and expiry on the same edge counts as release
    bus.req = 3'b001;
    for (int i = 0; i < 40 && !(cur >= 0 && held == MAX_HOLD); i++) cycle();
    check("hold_reach", dut.hold_q, 8'(MAX_HOLD));
    bus.req = 3'b010;
    cycle();
    check("coincide_preempt", bus.preempt, 8'd0);
    run(6);
    bus.req = 3'b000;
    run(4);

    // Freeze in IDLE blocks new grants
    bus.freeze = 1'b1;
    bus.req    = 3'b100;
    run(10);
    check("frozen_gnt", bus.gnt, 8'h00);
    bus.freeze = 1'b0;
    cycle();
    check("unfrozen_gnt", bus.gnt, 8'h04);
    bus.req = 3'b000;
    run(4);

    // Freeze raised mid-grant neither shortens it nor lets IDLE re-grant
    bus.req = 3'b011;
    run(2);
    bus.freeze = 1'b1;
    run(5);
    bus.req = 3'b010;
    run(6);
    check("freeze_holds_idle", bus.gnt, 8'h00);
    bus.freeze = 1'b0;
    run(4);
    bus.req = 3'b000;
    run(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 3'($urandom_range(0, 7));
      bus.freeze = ($urandom_range(0, 9) == 0);
      cycle();
    end
    bus.freeze = 1'b0;
    bus.req    = 3'b000;
    run(4);

    // Asynchronous reset mid-grant, then restart with req=110
    bus.req = 3'b001;
    run(3);
    @(posedge clk);
    model_step(bus.req, bus.freeze);
    #2 reset = 1'b0;
    #1;
    check("async_gnt",     bus.gnt,     8'h00);
    check("async_owner",   bus.owner,   8'd3);
    check("async_preempt", bus.preempt, 8'd0);
    check("async_busy",    bus.busy,    8'd0);
    model_reset();
    @(negedge clk) bus.req = 3'b110;
    @(posedge clk);
    @(negedge clk);
    check("held_in_reset", bus.gnt, 8'h00);
    reset = 1'b1;
    cycle();
    check("post_reset_winner", bus.gnt, 8'h02);
    run(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, is the maximum number of granted cycles before the owner is preempted when another request is pending; legal range 1..255.
REQ-002 Parameter TURNAROUND, default 1, is the number of all-grants-low cycles inserted between two owners of data_bus; legal range 0..3.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 reset  input  1  asynchronous, active-low reset; reset==0 SHALL force the reset state immediately, independent of clk.
REQ-005 req  input  3  per-requester bus request: bit0 CPU control, bit1 program loader/DMA, bit2 debug port.
REQ-006 freeze  input  1  high SHALL block issue of new grants; the current grant is unaffected.
REQ-007 gnt  output  3  registered one-hot grant; the granted requester alone may drive data_bus.
REQ-008 owner  output  2  index of the granted requester; 2'b11 when no grant is active.
REQ-009 busy  output  1  high while gnt is nonzero or a turnaround is in progress.
REQ-010 preempt  output  1  one-cycle pulse on the edge a grant is revoked by MAX_HOLD expiry.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT and TURN.
REQ-012 gnt SHALL never have more than one bit set, and SHALL be 3'b000 in IDLE and TURN.
REQ-013 In IDLE with freeze==0 and req!=0, the winning gnt bit SHALL be set on that same rising edge and the FSM SHALL enter GRANT (request-to-grant latency: 1 edge).
REQ-014 In IDLE with freeze==1 or req==0, the FSM SHALL remain in IDLE.
REQ-015 Winner selection SHALL be round-robin from a pointer last; search order is last+1, last+2, last (mod 3).
REQ-016 last SHALL be updated to the winner index on every grant.
REQ-017 hold_cnt (8 bits) SHALL load 1 on grant and increment once per GRANT cycle, saturating at MAX_HOLD.
REQ-018 In GRANT, if req[owner]==0, the grant SHALL be cleared on that edge and the FSM SHALL go to TURN; this is a release, with preempt==0.
REQ-019 In GRANT, if req[owner]==1, hold_cnt==MAX_HOLD and any other req bit is set, the grant SHALL be cleared, preempt SHALL pulse for one cycle, and the FSM SHALL go to TURN.
REQ-020 In GRANT, if req[owner]==1, hold_cnt==MAX_HOLD and no other req bit is set, the grant SHALL be held and hold_cnt SHALL stay at MAX_HOLD.
REQ-021 If release and expiry coincide on the same edge, the event SHALL be treated as a release (preempt==0).
REQ-022 TURN SHALL last exactly TURNAROUND cycles with gnt==0 and busy==1, then go to IDLE.
REQ-023 With TURNAROUND==0, GRANT SHALL exit directly to IDLE; the next grant SHALL still need one IDLE edge, so gnt is always low for at least 1 cycle between owners.
REQ-024 Requests that assert or deassert during TURN SHALL only be evaluated in IDLE.
REQ-025 A preempted requester that keeps req high SHALL be granted again only after every other pending requester (follows from REQ-015/016).
REQ-026 owner SHALL equal the index of the set gnt bit, or 2'b11 when gnt==0.
REQ-027 freeze rising during GRANT SHALL NOT shorten the grant; the FSM SHALL stay in IDLE after the grant until freeze==0.

Reset
REQ-028 reset==0 SHALL set: state IDLE, gnt 3'b000, owner 2'b11, busy 0, preempt 0, hold_cnt 0, last 2 (so requester 0 wins the first arbitration).
REQ-029 Reset asserted mid-grant or mid-turnaround SHALL drop gnt asynchronously, with no preempt pulse.
REQ-030 The first grant after reset release SHALL be issued no earlier than the first rising edge on which reset==1.

Verification
REQ-031 After reset, req=3'b111 held, defaults -> gnt 001 for 16 cycles, preempt pulse, 1 TURN cycle, gnt 010 for 16 cycles, TURN, gnt 100, then gnt 001 again.
REQ-032 req=3'b010 raised for 5 cycles then dropped, others 0 -> gnt 010 on the first edge, held 5 cycles, then gnt 000 with busy=1 for 1 cycle, then IDLE with busy=0 and preempt never set.
REQ-033 req[0] alone held for 40 cycles -> gnt 001 continuous for 40 cycles, hold_cnt saturates at 16, no preempt.
REQ-034 req[0] granted; on its 16th cycle req[0] drops and req[1] rises in the same cycle -> release (preempt=0), TURN, then gnt 010.
REQ-035 freeze=1 with req=3'b100 in IDLE for 10 cycles -> gnt stays 000; on freeze=0, gnt 100 on the next edge.
REQ-036 Reset pulsed low mid-grant between clock edges -> gnt 000 and owner 11 immediately; after release with req=3'b110, first grant is 010.
